// File: rtl/issue_slot_pkg.sv
// issue_slot_pkg: shared types and default sizes for the issue slot scheduler.
// Slot lifecycle states and per-slot source tag storage types.
package issue_slot_pkg;

    localparam int DefEntryCount = 8;
    localparam int DefEnqWidth   = 2;
    localparam int DefSelWidth   = 2;
    localparam int DefSrcNum     = 2;
    localparam int DefWakeWidth  = 2;
    localparam int DefTagWidth   = 6;
    localparam int IdxWidth      = $clog2(DefEntryCount);

    typedef enum logic [1:0] {
        FREE,
        WAIT,
        ISSUED
    } slot_state_e;

    typedef logic [DefTagWidth-1:0] tag_t;
    typedef tag_t [DefSrcNum-1:0] slot_tags_t;
    typedef slot_tags_t [DefEntryCount-1:0] tag_array_t;

endpackage

// File: rtl/issue_slot_scheduler_if.sv
// issue_slot_scheduler_if: enqueue, wakeup, issue and age-selector bundle.
// ISSUE_SLOT_REPLAY_EN adds the release/replay ports.
interface issue_slot_scheduler_if
    import issue_slot_pkg::*;
#(
    parameter int EntryCount = DefEntryCount,
    parameter int EnqWidth   = DefEnqWidth,
    parameter int SelWidth   = DefSelWidth,
    parameter int SrcNum     = DefSrcNum,
    parameter int WakeWidth  = DefWakeWidth,
    parameter int TagWidth   = DefTagWidth
);
    localparam int IdxW = $clog2(EntryCount);

    logic                                           flush_i;
    logic [EnqWidth-1:0]                            enq_vld_i;
    logic [EnqWidth-1:0]                            enq_rdy_o;
    logic [EnqWidth-1:0][SrcNum-1:0][TagWidth-1:0]  enq_src_tag_i;
    logic [EnqWidth-1:0][SrcNum-1:0]                enq_src_rdy_i;
    logic [EnqWidth-1:0][IdxW-1:0]                  enq_idx_o;
    logic [WakeWidth-1:0]                           wake_vld_i;
    logic [WakeWidth-1:0][TagWidth-1:0]             wake_tag_i;
    logic [SelWidth-1:0]                            iss_vld_o;
    logic [SelWidth-1:0]                            iss_rdy_i;
    logic [SelWidth-1:0][IdxW-1:0]                  iss_idx_o;
    logic [EnqWidth-1:0]                            am_enq_fire_o;
    logic [EnqWidth-1:0][EntryCount-1:0]            am_enq_mask_o;
    logic                                           am_deq_fire_o;
    logic [EntryCount-1:0]                          am_deq_mask_o;
    logic [EntryCount-1:0]                          am_sel_mask_o;
    logic [EntryCount-1:0]                          am_vld_o;
    logic [SelWidth-1:0][EntryCount-1:0]            am_result_i;
`ifdef ISSUE_SLOT_REPLAY_EN
    logic                                           rel_vld_i;
    logic [EntryCount-1:0]                          rel_mask_i;
    logic                                           rpl_vld_i;
    logic [EntryCount-1:0]                          rpl_mask_i;
`endif

    modport slave (
`ifdef ISSUE_SLOT_REPLAY_EN
        input  rel_vld_i, rel_mask_i, rpl_vld_i, rpl_mask_i,
`endif
        input  flush_i, enq_vld_i, enq_src_tag_i, enq_src_rdy_i,
        input  wake_vld_i, wake_tag_i, iss_rdy_i, am_result_i,
        output enq_rdy_o, enq_idx_o, iss_vld_o, iss_idx_o,
        output am_enq_fire_o, am_enq_mask_o, am_deq_fire_o,
        output am_deq_mask_o, am_sel_mask_o, am_vld_o
    );

    modport master (
`ifdef ISSUE_SLOT_REPLAY_EN
        output rel_vld_i, rel_mask_i, rpl_vld_i, rpl_mask_i,
`endif
        output flush_i, enq_vld_i, enq_src_tag_i, enq_src_rdy_i,
        output wake_vld_i, wake_tag_i, iss_rdy_i, am_result_i,
        input  enq_rdy_o, enq_idx_o, iss_vld_o, iss_idx_o,
        input  am_enq_fire_o, am_enq_mask_o, am_deq_fire_o,
        input  am_deq_mask_o, am_sel_mask_o, am_vld_o
    );

endinterface

// File: rtl/issue_slot_free_alloc.sv
// issue_slot_free_alloc: picks the lowest-index free slots, one per lane,
// as one-hot masks, and counts how many slots are free.
module issue_slot_free_alloc #(
    parameter int EntryCount = 8,
    parameter int EnqWidth   = 2
) (
    input  logic [EntryCount-1:0]                free,
    output logic [EnqWidth-1:0][EntryCount-1:0]  alloc_mask,
    output logic [$clog2(EntryCount+1)-1:0]      free_cnt
);
    localparam int CntW = $clog2(EntryCount + 1);

    logic [CntW-1:0] cnt;

    // Scan upward; the k-th free slot found goes to lane k.
    always_comb begin
        alloc_mask = '0;
        cnt        = '0;
        for (int i = 0; i < EntryCount; i++) begin
            if (free[i]) begin
                for (int j = 0; j < EnqWidth; j++) begin
                    if (cnt == CntW'(j)) alloc_mask[j][i] = 1'b1;
                end
                cnt = cnt + 1'b1;
            end
        end
    end

    assign free_cnt = cnt;

endmodule

// File: rtl/issue_slot_scheduler.sv
// issue_slot_scheduler: slot allocation, tag wakeup and issue handshake
// around an external age-matrix selector. Option: ISSUE_SLOT_REPLAY_EN.
module issue_slot_scheduler
    import issue_slot_pkg::*;
#(
    parameter int EntryCount = DefEntryCount,
    parameter int EnqWidth   = DefEnqWidth,
    parameter int SelWidth   = DefSelWidth,
    parameter int SrcNum     = DefSrcNum,
    parameter int WakeWidth  = DefWakeWidth,
    parameter int TagWidth   = DefTagWidth
) (
    input  logic                       clk,
    input  logic                       rstn,
    issue_slot_scheduler_if.slave      bus
);
    localparam int IdxW = $clog2(EntryCount);
    localparam int CntW = $clog2(EntryCount + 1);

    slot_state_e                                   state [EntryCount];
    logic [EntryCount-1:0][SrcNum-1:0]             src_rdy;
    logic [EntryCount-1:0][SrcNum-1:0][TagWidth-1:0] src_tag;

    logic [EntryCount-1:0]                slot_free;
    logic [EntryCount-1:0]                slot_vld;
    logic [EntryCount-1:0]                sel_mask;
    logic [EntryCount-1:0]                fired;
    logic [EntryCount-1:0]                deq_mask;
    logic [EnqWidth-1:0][EntryCount-1:0]  alloc_mask;
    logic [CntW-1:0]                      free_cnt;
    logic [EnqWidth-1:0]                  enq_rdy;
    logic [EnqWidth-1:0]                  enq_fire;
    logic [SelWidth-1:0]                  iss_vld;
    logic [SelWidth-1:0]                  iss_fire;
    logic [EntryCount-1:0][SrcNum-1:0]    slot_hit;
    logic [EnqWidth-1:0][SrcNum-1:0]      enq_hit;

    function automatic logic [IdxW-1:0] enc(
        input logic [EntryCount-1:0] m
    );
        enc = '0;
        for (int i = 0; i < EntryCount; i++) begin
            if (m[i]) enc = enc | IdxW'(i);
        end
    endfunction

    function automatic logic woke(
        input logic [TagWidth-1:0]                 t,
        input logic [WakeWidth-1:0]                v,
        input logic [WakeWidth-1:0][TagWidth-1:0]  w
    );
        woke = 1'b0;
        for (int k = 0; k < WakeWidth; k++) begin
            if (v[k] && w[k] == t) woke = 1'b1;
        end
    endfunction

    issue_slot_free_alloc #(
        .EntryCount (EntryCount),
        .EnqWidth   (EnqWidth)
    ) u_alloc (
        .free       (slot_free),
        .alloc_mask (alloc_mask),
        .free_cnt   (free_cnt)
    );

    // Per-slot status vectors seen by the allocator and the selector.
    always_comb begin
        for (int e = 0; e < EntryCount; e++) begin
            slot_free[e] = (state[e] == FREE);
            slot_vld[e]  = (state[e] != FREE);
            sel_mask[e]  = (state[e] == WAIT) && (&src_rdy[e]);
        end
    end

    // Tag matches for stored sources and for sources entering this cycle.
    always_comb begin
        for (int e = 0; e < EntryCount; e++) begin
            for (int s = 0; s < SrcNum; s++) begin
                slot_hit[e][s] = woke(src_tag[e][s],
                                      bus.wake_vld_i, bus.wake_tag_i);
            end
        end
        for (int j = 0; j < EnqWidth; j++) begin
            for (int s = 0; s < SrcNum; s++) begin
                enq_hit[j][s] = woke(bus.enq_src_tag_i[j][s],
                                     bus.wake_vld_i, bus.wake_tag_i);
            end
        end
    end

    // Enqueue and issue handshakes; flush blocks both sides.
    always_comb begin
        fired = '0;
        for (int j = 0; j < EnqWidth; j++) begin
            enq_rdy[j]  = (free_cnt > CntW'(j)) && !bus.flush_i;
            enq_fire[j] = bus.enq_vld_i[j] && enq_rdy[j];
        end
        for (int s = 0; s < SelWidth; s++) begin
            iss_vld[s]  = (|bus.am_result_i[s]) && !bus.flush_i;
            iss_fire[s] = iss_vld[s] && bus.iss_rdy_i[s];
            if (iss_fire[s]) fired = fired | bus.am_result_i[s];
        end
    end

    // Slots leaving the queue this cycle, as the selector must see them.
    always_comb begin
        if (bus.flush_i) begin
            deq_mask = slot_vld;
        end else begin
`ifdef ISSUE_SLOT_REPLAY_EN
            deq_mask = '0;
            for (int e = 0; e < EntryCount; e++) begin
                deq_mask[e] = bus.rel_vld_i && bus.rel_mask_i[e]
                              && (state[e] == ISSUED);
            end
`else
            deq_mask = fired;
`endif
        end
    end

    // Output bundle assembly.
    always_comb begin
        for (int j = 0; j < EnqWidth; j++) begin
            bus.enq_idx_o[j]     = enc(alloc_mask[j]);
            bus.am_enq_mask_o[j] = enq_fire[j] ? alloc_mask[j] : '0;
        end
        for (int s = 0; s < SelWidth; s++) begin
            bus.iss_idx_o[s] = enc(bus.am_result_i[s]);
        end
    end

    assign bus.enq_rdy_o     = enq_rdy;
    assign bus.iss_vld_o     = iss_vld;
    assign bus.am_enq_fire_o = enq_fire;
    assign bus.am_deq_fire_o = |deq_mask;
    assign bus.am_deq_mask_o = deq_mask;
    assign bus.am_sel_mask_o = sel_mask;
    assign bus.am_vld_o      = slot_vld;

    // Slot lifecycle, source readiness and tag storage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int e = 0; e < EntryCount; e++) state[e] <= FREE;
            src_rdy <= '0;
            src_tag <= '0;
        end else if (bus.flush_i) begin
            for (int e = 0; e < EntryCount; e++) state[e] <= FREE;
            src_rdy <= '0;
        end else begin
            for (int e = 0; e < EntryCount; e++) begin
                case (state[e])
                    FREE: begin
                        for (int j = 0; j < EnqWidth; j++) begin
                            if (enq_fire[j] && alloc_mask[j][e]) begin
                                state[e]   <= WAIT;
                                src_tag[e] <= bus.enq_src_tag_i[j];
                                src_rdy[e] <= bus.enq_src_rdy_i[j]
                                              | enq_hit[j];
                            end
                        end
                    end
                    WAIT: begin
                        src_rdy[e] <= src_rdy[e] | slot_hit[e];
`ifdef ISSUE_SLOT_REPLAY_EN
                        if (fired[e]) state[e] <= ISSUED;
`else
                        if (fired[e]) state[e] <= FREE;
`endif
                    end
`ifdef ISSUE_SLOT_REPLAY_EN
                    ISSUED: begin
                        if (bus.rel_vld_i && bus.rel_mask_i[e])
                            state[e] <= FREE;
                        else if (bus.rpl_vld_i && bus.rpl_mask_i[e])
                            state[e] <= WAIT;
                    end
`endif
                    default: state[e] <= FREE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_issue_slot_scheduler.sv
// tb_issue_slot_scheduler: vector table plus scoreboard for the scheduler.
// Selector results are supplied by the vectors in oldest-first order.
module tb_issue_slot_scheduler;
    import issue_slot_pkg::*;

    typedef struct {
        logic              flush;
        logic [1:0]        enq_vld;
        logic [1:0][1:0][5:0] tags;
        logic [1:0][1:0]   src_rdy;
        logic [1:0]        wake_vld;
        logic [1:0][5:0]   wake_tag;
        logic [1:0]        iss_rdy;
        logic [1:0][7:0]   res;
        logic              rel_vld;
        logic [7:0]        rel_mask;
        logic              rpl_vld;
        logic [7:0]        rpl_mask;
        logic [1:0]        e_enq_rdy;
        logic [5:0]        e_enq_idx;
        logic [1:0]        e_iss_vld;
        logic [5:0]        e_iss_idx;
        logic [7:0]        e_deq;
        logic [7:0]        e_sel;
        logic [7:0]        e_vld;
    } vec_t;

    typedef struct {
        logic [1:0] enq_rdy;
        logic [5:0] enq_idx;
        logic [1:0] iss_vld;
        logic [5:0] iss_idx;
        logic [1:0] enq_fire;
        logic       deq_fire;
        logic [7:0] deq;
        logic [7:0] sel;
        logic [7:0] vld;
    } exp_t;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];
    vec_t tbl[$];

    issue_slot_scheduler_if bus_if ();

    issue_slot_scheduler dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic fl, input logic [1:0] ev, input logic [23:0] tg,
        input logic [3:0] sr, input logic [1:0] wv, input logic [11:0] wt,
        input logic [1:0] ir, input logic [7:0] r1, input logic [7:0] r0,
        input logic [1:0] er, input logic [5:0] ei, input logic [1:0] iv,
        input logic [5:0] ii, input logic [7:0] dq, input logic [7:0] sl,
        input logic [7:0] vd
    );
        vec_t v;
        v.flush = fl;  v.enq_vld = ev;  v.tags = tg;  v.src_rdy = sr;
        v.wake_vld = wv;  v.wake_tag = wt;  v.iss_rdy = ir;
        v.res = {r1, r0};
        v.rel_vld = 1'b0;  v.rel_mask = '0;
        v.rpl_vld = 1'b0;  v.rpl_mask = '0;
        v.e_enq_rdy = er;  v.e_enq_idx = ei;  v.e_iss_vld = iv;
        v.e_iss_idx = ii;  v.e_deq = dq;  v.e_sel = sl;  v.e_vld = vd;
        return v;
    endfunction

    task automatic check(input string nm, input logic [15:0] act,
                         input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic zero_inputs();
        bus_if.flush_i       = 1'b0;
        bus_if.enq_vld_i     = '0;
        bus_if.enq_src_tag_i = '0;
        bus_if.enq_src_rdy_i = '0;
        bus_if.wake_vld_i    = '0;
        bus_if.wake_tag_i    = '0;
        bus_if.iss_rdy_i     = '0;
        bus_if.am_result_i   = '0;
`ifdef ISSUE_SLOT_REPLAY_EN
        bus_if.rel_vld_i     = 1'b0;
        bus_if.rel_mask_i    = '0;
        bus_if.rpl_vld_i     = 1'b0;
        bus_if.rpl_mask_i    = '0;
`endif
    endtask

    task automatic compare(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", nm);
            return;
        end
        e = sb.pop_front();
        check({nm, ".enq_rdy"},  16'(bus_if.enq_rdy_o),     16'(e.enq_rdy));
        check({nm, ".enq_idx"},  16'(bus_if.enq_idx_o),     16'(e.enq_idx));
        check({nm, ".iss_vld"},  16'(bus_if.iss_vld_o),     16'(e.iss_vld));
        check({nm, ".iss_idx"},  16'(bus_if.iss_idx_o),     16'(e.iss_idx));
        check({nm, ".enq_fire"}, 16'(bus_if.am_enq_fire_o), 16'(e.enq_fire));
        check({nm, ".deq_fire"}, 16'(bus_if.am_deq_fire_o), 16'(e.deq_fire));
        check({nm, ".deq_mask"}, 16'(bus_if.am_deq_mask_o), 16'(e.deq));
        check({nm, ".sel_mask"}, 16'(bus_if.am_sel_mask_o), 16'(e.sel));
        check({nm, ".vld"},      16'(bus_if.am_vld_o),      16'(e.vld));
    endtask

    task automatic apply(input vec_t v, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        bus_if.flush_i       = v.flush;
        bus_if.enq_vld_i     = v.enq_vld;
        bus_if.enq_src_tag_i = v.tags;
        bus_if.enq_src_rdy_i = v.src_rdy;
        bus_if.wake_vld_i    = v.wake_vld;
        bus_if.wake_tag_i    = v.wake_tag;
        bus_if.iss_rdy_i     = v.iss_rdy;
        bus_if.am_result_i   = v.res;
`ifdef ISSUE_SLOT_REPLAY_EN
        bus_if.rel_vld_i     = v.rel_vld;
        bus_if.rel_mask_i    = v.rel_mask;
        bus_if.rpl_vld_i     = v.rpl_vld;
        bus_if.rpl_mask_i    = v.rpl_mask;
`endif
        e.enq_rdy  = v.e_enq_rdy;
        e.enq_idx  = v.e_enq_idx;
        e.iss_vld  = v.e_iss_vld;
        e.iss_idx  = v.e_iss_idx;
        e.enq_fire = v.enq_vld & v.e_enq_rdy;
        e.deq_fire = |v.e_deq;
        e.deq      = v.e_deq;
        e.sel      = v.e_sel;
        e.vld      = v.e_vld;
        sb.push_back(e);
        @(negedge clk);
        compare(nm);
    endtask

    initial begin
        vec_t v;
        n_cmp = 0;
        n_bad = 0;
        rstn  = 1'b0;
        zero_inputs();

        // idle out of reset, then slots 0/1 enqueued ready and presented
        tbl.push_back(mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b00,
                         8'h00, 8'h00, 2'b11, 6'h08, 2'b00, 6'h00,
                         8'h00, 8'h00, 8'h00));
        tbl.push_back(mk(0, 2'b11, {6'd13, 6'd12, 6'd11, 6'd10}, 4'hF,
                         2'b00, 12'h0, 2'b00, 8'h00, 8'h00,
                         2'b11, 6'h08, 2'b00, 6'h00, 8'h00, 8'h00, 8'h00));
        tbl.push_back(mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b00,
                         8'h02, 8'h01, 2'b11, 6'h1A, 2'b11, 6'h08,
                         8'h00, 8'h03, 8'h03));
        // only port 0 accepted; slot 1 comes back on port 0
`ifdef ISSUE_SLOT_REPLAY_EN
        tbl.push_back(mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b01,
                         8'h02, 8'h01, 2'b11, 6'h1A, 2'b11, 6'h08,
                         8'h00, 8'h03, 8'h03));
        tbl.push_back(mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b01,
                         8'h00, 8'h02, 2'b11, 6'h1A, 2'b01, 6'h01,
                         8'h00, 8'h02, 8'h03));
        v = mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b00, 8'h00, 8'h00,
               2'b11, 6'h1A, 2'b00, 6'h00, 8'h03, 8'h00, 8'h03);
        v.rel_vld = 1'b1;
        v.rel_mask = 8'h03;
        tbl.push_back(v);
`else
        tbl.push_back(mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b01,
                         8'h02, 8'h01, 2'b11, 6'h1A, 2'b11, 6'h08,
                         8'h01, 8'h03, 8'h03));
        tbl.push_back(mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b01,
                         8'h00, 8'h02, 2'b11, 6'h10, 2'b01, 6'h01,
                         8'h02, 8'h02, 8'h02));
`endif
        // fill all eight slots, src0 unready; slot 3 waits on tag 5
        tbl.push_back(mk(0, 2'b11, {6'd51, 6'd31, 6'd50, 6'd30}, 4'hA,
                         2'b00, 12'h0, 2'b00, 8'h00, 8'h00,
                         2'b11, 6'h08, 2'b00, 6'h00, 8'h00, 8'h00, 8'h00));
        tbl.push_back(mk(0, 2'b11, {6'd53, 6'd5, 6'd52, 6'd32}, 4'hA,
                         2'b00, 12'h0, 2'b00, 8'h00, 8'h00,
                         2'b11, 6'h1A, 2'b00, 6'h00, 8'h00, 8'h00, 8'h03));
        tbl.push_back(mk(0, 2'b11, {6'd55, 6'd35, 6'd54, 6'd34}, 4'hA,
                         2'b00, 12'h0, 2'b00, 8'h00, 8'h00,
                         2'b11, 6'h2C, 2'b00, 6'h00, 8'h00, 8'h00, 8'h0F));
        tbl.push_back(mk(0, 2'b11, {6'd57, 6'd37, 6'd56, 6'd36}, 4'hA,
                         2'b00, 12'h0, 2'b00, 8'h00, 8'h00,
                         2'b11, 6'h3E, 2'b00, 6'h00, 8'h00, 8'h00, 8'h3F));
        tbl.push_back(mk(0, 2'b11, 24'h0, 4'h0, 2'b00, 12'h0, 2'b00,
                         8'h00, 8'h00, 2'b00, 6'h00, 2'b00, 6'h00,
                         8'h00, 8'h00, 8'hFF));
        tbl.push_back(mk(0, 2'b00, 24'h0, 4'h0, 2'b01, {6'd0, 6'd5},
                         2'b00, 8'h00, 8'h00, 2'b00, 6'h00, 2'b00, 6'h00,
                         8'h00, 8'h00, 8'hFF));
`ifdef ISSUE_SLOT_REPLAY_EN
        tbl.push_back(mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b01,
                         8'h00, 8'h08, 2'b00, 6'h00, 2'b01, 6'h03,
                         8'h00, 8'h08, 8'hFF));
        v = mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b00, 8'h00, 8'h00,
               2'b00, 6'h00, 2'b00, 6'h00, 8'h08, 8'h00, 8'hFF);
        v.rel_vld = 1'b1;
        v.rel_mask = 8'h08;
        tbl.push_back(v);
`else
        tbl.push_back(mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b01,
                         8'h00, 8'h08, 2'b00, 6'h00, 2'b01, 6'h03,
                         8'h08, 8'h08, 8'hFF));
`endif
        tbl.push_back(mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b00,
                         8'h00, 8'h00, 2'b01, 6'h03, 2'b00, 6'h00,
                         8'h00, 8'h00, 8'hF7));
        // same-cycle wakeup of an entering source (tag 9)
        tbl.push_back(mk(0, 2'b01, {6'd0, 6'd0, 6'd9, 6'd9}, 4'h0,
                         2'b01, {6'd0, 6'd9}, 2'b00, 8'h00, 8'h00,
                         2'b01, 6'h03, 2'b00, 6'h00, 8'h00, 8'h00, 8'hF7));
        tbl.push_back(mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b00,
                         8'h00, 8'h08, 2'b00, 6'h00, 2'b01, 6'h03,
                         8'h00, 8'h08, 8'hFF));
        // issue slot 3 while waking slots 0/1, then issue those two
`ifdef ISSUE_SLOT_REPLAY_EN
        tbl.push_back(mk(0, 2'b00, 24'h0, 4'h0, 2'b11, {6'd31, 6'd30},
                         2'b01, 8'h00, 8'h08, 2'b00, 6'h00, 2'b01, 6'h03,
                         8'h00, 8'h08, 8'hFF));
        tbl.push_back(mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b11,
                         8'h02, 8'h01, 2'b00, 6'h00, 2'b11, 6'h08,
                         8'h00, 8'h03, 8'hFF));
        v = mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b00, 8'h00, 8'h00,
               2'b00, 6'h00, 2'b00, 6'h00, 8'h0B, 8'h00, 8'hFF);
        v.rel_vld = 1'b1;
        v.rel_mask = 8'h0B;
        tbl.push_back(v);
`else
        tbl.push_back(mk(0, 2'b00, 24'h0, 4'h0, 2'b11, {6'd31, 6'd30},
                         2'b01, 8'h00, 8'h08, 2'b00, 6'h00, 2'b01, 6'h03,
                         8'h08, 8'h08, 8'hFF));
        tbl.push_back(mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b11,
                         8'h02, 8'h01, 2'b01, 6'h03, 2'b11, 6'h08,
                         8'h03, 8'h03, 8'hF7));
`endif
        // flush with five valid slots and an enqueue attempt
        tbl.push_back(mk(1, 2'b11, 24'h0, 4'hF, 2'b00, 12'h0, 2'b00,
                         8'h00, 8'h00, 2'b00, 6'h08, 2'b00, 6'h00,
                         8'hF4, 8'h00, 8'hF4));
        tbl.push_back(mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b00,
                         8'h00, 8'h00, 2'b11, 6'h08, 2'b00, 6'h00,
                         8'h00, 8'h00, 8'h00));
        // lane 1 alone fires and keeps slot 1
        tbl.push_back(mk(0, 2'b10, {6'd63, 6'd62, 6'd61, 6'd60}, 4'hF,
                         2'b00, 12'h0, 2'b00, 8'h00, 8'h00,
                         2'b11, 6'h08, 2'b00, 6'h00, 8'h00, 8'h00, 8'h00));
        tbl.push_back(mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b00,
                         8'h00, 8'h00, 2'b11, 6'h10, 2'b00, 6'h00,
                         8'h00, 8'h02, 8'h02));

        // reset state
        @(negedge clk);
        check("rst.vld",     16'(bus_if.am_vld_o),      16'h0000);
        check("rst.enq_rdy", 16'(bus_if.enq_rdy_o),     16'h0003);
        check("rst.iss_vld", 16'(bus_if.iss_vld_o),     16'h0000);
        check("rst.deq",     16'(bus_if.am_deq_fire_o), 16'h0000);
        rstn = 1'b1;

        foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

        // asynchronous reset in mid-cycle with slot 1 valid
        @(posedge clk);
        #1;
        zero_inputs();
        #2;
        rstn = 1'b0;
        #1;
        check("arst.vld",     16'(bus_if.am_vld_o),  16'h0000);
        check("arst.enq_rdy", 16'(bus_if.enq_rdy_o), 16'h0003);
        @(negedge clk);
        rstn = 1'b1;
        apply(mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b00, 8'h00, 8'h00,
                 2'b11, 6'h08, 2'b00, 6'h00, 8'h00, 8'h00, 8'h00), "arst1");

`ifdef ISSUE_SLOT_REPLAY_EN
        // slot 2: issue, replay, re-issue, release
        apply(mk(0, 2'b11, 24'h0, 4'hF, 2'b00, 12'h0, 2'b00, 8'h00, 8'h00,
                 2'b11, 6'h08, 2'b00, 6'h00, 8'h00, 8'h00, 8'h00), "r0");
        apply(mk(0, 2'b01, 24'h0, 4'hF, 2'b00, 12'h0, 2'b00, 8'h00, 8'h00,
                 2'b11, 6'h1A, 2'b00, 6'h00, 8'h00, 8'h03, 8'h03), "r1");
        apply(mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b01, 8'h00, 8'h04,
                 2'b11, 6'h23, 2'b01, 6'h02, 8'h00, 8'h07, 8'h07), "r2");
        v = mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b00, 8'h00, 8'h00,
               2'b11, 6'h23, 2'b00, 6'h00, 8'h00, 8'h03, 8'h07);
        v.rpl_vld = 1'b1;
        v.rpl_mask = 8'h04;
        apply(v, "r3");
        apply(mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b01, 8'h00, 8'h04,
                 2'b11, 6'h23, 2'b01, 6'h02, 8'h00, 8'h07, 8'h07), "r4");
        v = mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b00, 8'h00, 8'h00,
               2'b11, 6'h23, 2'b00, 6'h00, 8'h04, 8'h03, 8'h07);
        v.rel_vld = 1'b1;
        v.rel_mask = 8'h04;
        apply(v, "r5");
        apply(mk(0, 2'b00, 24'h0, 4'h0, 2'b00, 12'h0, 2'b00, 8'h00, 8'h00,
                 2'b11, 6'h1A, 2'b00, 6'h00, 8'h00, 8'h03, 8'h03), "r6");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
